// File: rtl/alu_control_seq_pkg.sv
// Shared encodings for the sequenced ALU control unit:
// ALUOp classes, function fields, operation codes and FSM states.
package alu_control_seq_pkg;

  localparam logic [2:0] ALUOP_LWSW   = 3'b000;
  localparam logic [2:0] ALUOP_BRANCH = 3'b001;
  localparam logic [2:0] ALUOP_LUI    = 3'b011;
  localparam logic [2:0] ALUOP_ADDI   = 3'b100;
  localparam logic [2:0] ALUOP_ORI    = 3'b101;
  localparam logic [2:0] ALUOP_ANDI   = 3'b110;
  localparam logic [2:0] ALUOP_RTYPE  = 3'b111;

  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  localparam logic [3:0] OPC_AND     = 4'b0000;
  localparam logic [3:0] OPC_OR      = 4'b0001;
  localparam logic [3:0] OPC_NOR     = 4'b0010;
  localparam logic [3:0] OPC_ADD     = 4'b0011;
  localparam logic [3:0] OPC_SUB     = 4'b0100;
  localparam logic [3:0] OPC_SLL     = 4'b0101;
  localparam logic [3:0] OPC_SRL     = 4'b0110;
  localparam logic [3:0] OPC_SLT     = 4'b0111;
  localparam logic [3:0] OPC_MFHI    = 4'b1000;
  localparam logic [3:0] OPC_NOP     = 4'b1001;
  localparam logic [3:0] OPC_MFLO    = 4'b1010;
  localparam logic [3:0] OPC_LUI     = 4'b1011;
  localparam logic [3:0] OPC_MULTDIV = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_control_seq_if.sv
// Control-unit side bundle of the ALU control sequencer:
// instruction inputs plus decode, start, stall and strobe outputs.
interface alu_control_seq_if #(
  parameter int OPERATION_WIDTH = 4
);
  logic                       enable;
  logic [2:0]                 ALUOp;
  logic [5:0]                 ALUFunction;
  logic [OPERATION_WIDTH-1:0] ALUOperation;
  logic                       MultiStart;
  logic                       MultiOp;
  logic                       Stall;
  logic                       HiLoWrite;
  logic                       Illegal;

  modport master (
    output enable, ALUOp, ALUFunction,
    input  ALUOperation, MultiStart, MultiOp,
    input  Stall, HiLoWrite, Illegal
  );

  modport slave (
    input  enable, ALUOp, ALUFunction,
    output ALUOperation, MultiStart, MultiOp,
    output Stall, HiLoWrite, Illegal
  );
endinterface

// File: rtl/alu_control_seq_op_decoder.sv
// Pure combinational ALUOp/function decode into an operation
// code plus mult/div and illegal classification.
module alu_op_decoder
  import alu_control_seq_pkg::*;
#(
  parameter int OPERATION_WIDTH = 4
) (
  input  logic [2:0]                 alu_op_i,
  input  logic [5:0]                 funct_i,
  output logic [OPERATION_WIDTH-1:0] op_o,
  output logic                       is_multdiv_o,
  output logic                       is_div_o,
  output logic                       is_illegal_o
);

  logic [3:0] code;

  always_comb begin
    code         = OPC_NOP;
    is_multdiv_o = 1'b0;
    is_div_o     = 1'b0;
    is_illegal_o = 1'b0;
    unique case (alu_op_i)
      ALUOP_LWSW:   code = OPC_ADD;
      ALUOP_BRANCH: code = OPC_SUB;
      ALUOP_LUI:    code = OPC_LUI;
      ALUOP_ADDI:   code = OPC_ADD;
      ALUOP_ORI:    code = OPC_OR;
      ALUOP_ANDI:   code = OPC_AND;
      ALUOP_RTYPE: begin
        unique case (funct_i)
          FN_AND:  code = OPC_AND;
          FN_OR:   code = OPC_OR;
          FN_NOR:  code = OPC_NOR;
          FN_ADD:  code = OPC_ADD;
          FN_SUB:  code = OPC_SUB;
          FN_SLL:  code = OPC_SLL;
          FN_SRL:  code = OPC_SRL;
          FN_SLT:  code = OPC_SLT;
          FN_MFHI: code = OPC_MFHI;
          FN_MFLO: code = OPC_MFLO;
          FN_MULT: begin
            code         = OPC_MULTDIV;
            is_multdiv_o = 1'b1;
          end
          FN_DIV: begin
            code         = OPC_MULTDIV;
            is_multdiv_o = 1'b1;
            is_div_o     = 1'b1;
          end
          default: is_illegal_o = 1'b1;
        endcase
      end
      default: is_illegal_o = 1'b1;
    endcase
  end

  assign op_o = OPERATION_WIDTH'(code);

endmodule

// File: rtl/alu_control_seq.sv
// ALU control with MULT/DIV sequencing: stalls the pipeline
// while the external mult/div unit runs its fixed latency.
module alu_control_seq
  import alu_control_seq_pkg::*;
#(
  parameter int MULT_LATENCY    = 4,
  parameter int DIV_LATENCY     = 16,
  parameter int OPERATION_WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  alu_control_seq_if.slave bus
);

  localparam int MAX_LAT =
    (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
  localparam int CNT_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  logic [OPERATION_WIDTH-1:0] op;
  logic is_multdiv, is_div, is_illegal;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             multi_op_q, multi_op_d;
  logic             illegal_q, illegal_d;
  logic             start, stall, hilo;

  alu_op_decoder #(
    .OPERATION_WIDTH(OPERATION_WIDTH)
  ) u_dec (
    .alu_op_i    (bus.ALUOp),
    .funct_i     (bus.ALUFunction),
    .op_o        (op),
    .is_multdiv_o(is_multdiv),
    .is_div_o    (is_div),
    .is_illegal_o(is_illegal)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    multi_op_d = multi_op_q;
    start      = 1'b0;
    stall      = 1'b0;
    hilo       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.enable && is_multdiv) begin
          start      = 1'b1;
          stall      = 1'b1;
          multi_op_d = is_div;
          cnt_d      = is_div ? CNT_W'(DIV_LATENCY - 1)
                              : CNT_W'(MULT_LATENCY - 1);
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE: begin
        // held MULT/DIV is ignored here; only IDLE may start
        hilo    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign illegal_d = bus.enable & is_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      multi_op_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      multi_op_q <= multi_op_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.ALUOperation = op;
  assign bus.MultiStart   = start;
  assign bus.MultiOp      = multi_op_q;
  assign bus.Stall        = stall;
  assign bus.HiLoWrite    = hilo;
  assign bus.Illegal      = illegal_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Randomised and directed bench for alu_control_seq against a
// cycle-timeline model of decode and MULT/DIV sequencing.
module tb_alu_control_seq;

  localparam int ML = 4;
  localparam int DL = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_control_seq_if #(.OPERATION_WIDTH(4)) bus ();

  alu_control_seq #(
    .MULT_LATENCY   (ML),
    .DIV_LATENCY    (DL),
    .OPERATION_WIDTH(4)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus.slave)
  );

  // reference decode table
  logic [5:0] rfn [12] = '{6'b100100, 6'b100101, 6'b100111,
    6'b100000, 6'b100010, 6'b000000, 6'b000010, 6'b101010,
    6'b010000, 6'b010010, 6'b011000, 6'b011010};
  logic [3:0] rcd [12] = '{4'b0000, 4'b0001, 4'b0010,
    4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
    4'b1000, 4'b1010, 4'b1100, 4'b1100};
  logic [2:0] iop [6] = '{3'b000, 3'b001, 3'b011,
    3'b100, 3'b101, 3'b110};
  logic [3:0] icd [6] = '{4'b0011, 4'b0100, 4'b1011,
    4'b0011, 4'b0001, 4'b0000};

  task automatic ref_dec(input logic [2:0] op, input logic [5:0] f,
                         output logic [3:0] code, output bit md,
                         output bit dv, output bit il);
    code = 4'b1001; md = 0; dv = 0; il = 1;
    for (int i = 0; i < 6; i++)
      if (op == iop[i]) begin code = icd[i]; il = 0; end
    if (op == 3'b111)
      for (int i = 0; i < 12; i++)
        if (f == rfn[i]) begin
          code = rcd[i]; il = 0;
          md = (i >= 10); dv = (i == 11);
        end
  endtask

  // model: k = cycles since acceptance of the current MULT/DIV, -1 if none
  int k = -1;
  int lat = 0;
  bit mop = 0;
  bit illq = 0;

  always @(posedge clk or posedge rst) begin
    logic [3:0] c; bit md, dv, il; int ek;
    if (rst) begin
      k = -1; mop = 0; illq = 0;
    end else begin
      ref_dec(bus.ALUOp, bus.ALUFunction, c, md, dv, il);
      ek = (k >= 0) ? k : ((bus.enable && md) ? 0 : -1);
      if (k < 0 && ek == 0) begin
        lat = dv ? DL : ML;
        mop = dv;
      end
      illq = bus.enable && il;
      k = (ek < 0 || ek + 1 > lat + 1) ? -1 : ek + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] c; bit md, dv, il; int ek, lc;
    ref_dec(bus.ALUOp, bus.ALUFunction, c, md, dv, il);
    ek = (k >= 0) ? k : ((bus.enable && md) ? 0 : -1);
    lc = (k >= 0) ? lat : (dv ? DL : ML);
    chk("ALUOperation", 32'(bus.ALUOperation), 32'(c));
    chk("MultiStart", 32'(bus.MultiStart), 32'(ek == 0));
    chk("Stall", 32'(bus.Stall), 32'(ek >= 0 && ek <= lc));
    chk("HiLoWrite", 32'(bus.HiLoWrite), 32'(ek == lc + 1));
    chk("MultiOp", 32'(bus.MultiOp), 32'(mop));
    chk("Illegal", 32'(bus.Illegal), 32'(illq));
  end

  task automatic drive(input bit en, input logic [2:0] op,
                       input logic [5:0] f);
    bus.enable = en; bus.ALUOp = op; bus.ALUFunction = f;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    drive(0, 3'b111, 6'b100000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0]  sv, hv, sv2;
    logic [18:0] dsv, dhv;
    idle();
    rst = 1;
    @(negedge clk);
    chk("reset Stall", 32'(bus.Stall), 32'd0);
    chk("reset MultiOp", 32'(bus.MultiOp), 32'd0);
    chk("reset Illegal", 32'(bus.Illegal), 32'd0);
    tick(); rst = 0;
    repeat (2) tick();

    // decode sweep
    for (int i = 0; i < 6; i++) begin
      drive(1, iop[i], 6'($urandom)); tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 3'b111, rfn[i]); tick();
    end
    drive(1, 3'b111, 6'b100010);
    @(negedge clk);
    chk("SUB code", 32'(bus.ALUOperation), 32'b0100);
    chk("sweep Illegal", 32'(bus.Illegal), 32'd0);
    tick(); drive(1, 3'b011, 6'b111111);
    @(negedge clk);
    chk("LUI code", 32'(bus.ALUOperation), 32'b1011);
    tick(); idle(); tick();

    // MULT timeline
    drive(1, 3'b111, 6'b011000);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      sv[c] = bus.Stall; hv[c] = bus.HiLoWrite;
      sv2[c] = bus.MultiStart;
      tick();
      if (c == 0) idle();
    end
    chk("MULT stall vec", 32'(sv), 32'b0011111);
    chk("MULT hilo vec", 32'(hv), 32'b0100000);
    chk("MULT start vec", 32'(sv2), 32'b0000001);
    chk("MULT MultiOp", 32'(bus.MultiOp), 32'd0);

    // DIV with enable dropped in cycle 3
    drive(1, 3'b111, 6'b011010);
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      dsv[c] = bus.Stall; dhv[c] = bus.HiLoWrite;
      if (c == 17) chk("DIV MultiOp", 32'(bus.MultiOp), 32'd1);
      tick();
      if (c == 2) idle();
    end
    chk("DIV stall vec", 32'(dsv), 32'h1FFFF);
    chk("DIV hilo vec", 32'(dhv), 32'h20000);

    // MULT held through DONE
    drive(1, 3'b111, 6'b011000);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      sv2[c] = bus.MultiStart;
      tick();
    end
    idle();
    chk("held start vec", 32'(sv2), 32'b1000001);
    repeat (8) tick();

    // reset mid-BUSY of a DIV
    drive(1, 3'b111, 6'b011010);
    tick(); idle();
    repeat (4) tick();
    rst = 1;
    @(negedge clk);
    chk("rst Stall", 32'(bus.Stall), 32'd0);
    chk("rst MultiOp", 32'(bus.MultiOp), 32'd0);
    tick(); rst = 0;
    drive(1, 3'b111, 6'b011000);
    tick(); idle();
    repeat (7) tick();

    // illegal encodings
    drive(1, 3'b010, 6'b100000);
    @(negedge clk);
    chk("ill code", 32'(bus.ALUOperation), 32'b1001);
    tick(); drive(1, 3'b111, 6'b111111);
    @(negedge clk);
    chk("ill next", 32'(bus.Illegal), 32'd1);
    tick(); drive(0, 3'b111, 6'b111111);
    @(negedge clk);
    chk("ill repeat", 32'(bus.Illegal), 32'd1);
    tick(); idle();
    @(negedge clk);
    chk("ill disabled", 32'(bus.Illegal), 32'd0);
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] op; logic [5:0] f;
      rst = ($urandom_range(0, 299) == 0);
      op = $urandom_range(0, 1) ? 3'b111 : 3'($urandom);
      f  = $urandom_range(0, 3) == 0 ? 6'($urandom)
                                     : rfn[$urandom_range(0, 11)];
      drive(1'($urandom), op, f);
      tick();
    end
    rst = 0; idle();
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
